// File: rtl/bcd_sub_pkg.sv
// bcd_sub_pkg: shared FSM states, BCD constants and digit-validity helper
package bcd_sub_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int BCD_RADIX = 10;
    localparam int BCD_MAX = 9;
    function automatic logic has_bad_digit(input logic [31:0] v, input int n);
        has_bad_digit = 1'b0;
        for (int i = 0; i < 8; i++)
            if (i < n && v[4*i +: 4] > 4'(BCD_MAX)) has_bad_digit = 1'b1;
    endfunction
endpackage

// File: rtl/bcd_digit_sub.sv
// bcd_digit_sub: one BCD digit subtract with borrow, ten's-complement on underflow
module bcd_digit_sub
    import bcd_sub_pkg::*;
(
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);
    logic [4:0] t;
    assign t = {1'b0, a_d} - {1'b0, b_d} - {4'b0, bin};
    assign bout = t[4];
    assign d = bout ? t[3:0] + 4'(BCD_RADIX) : t[3:0];
endmodule

// File: rtl/bcd_sub_seq.sv
// bcd_sub_seq: digit-serial BCD subtractor, LSD first; BCD_SUB_INVALID_CHECK_EN enables invalid-digit err
module bcd_sub_seq
    import bcd_sub_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  bin,
    output logic                  ready,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  bout,
    output logic                  err
);
    localparam int W = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS + 1);
    state_t state, state_n;
    logic [W-1:0] a_r, b_r, diff_r;
    logic [IW-1:0] idx;
    logic borrow, d_bout, accept, last;
    logic [3:0] d;
    assign accept = (state == IDLE) & start;
    assign last = idx == IW'(DIGITS - 1);
    assign ready = state == IDLE;
    assign valid = state == DONE;
    bcd_digit_sub u_digit (
        .a_d (a_r[3:0]),
        .b_d (b_r[3:0]),
        .bin (borrow),
        .d   (d),
        .bout(d_bout)
    );
    always_comb begin
        state_n = accept ? CALC : (state == CALC && last) ? DONE : (state == DONE) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end
    // Operands shift right so the active digit is always in bits [3:0]; results enter from the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            diff_r <= '0;
            borrow <= 1'b0;
            idx    <= '0;
        end else if (accept) begin
            a_r    <= a;
            b_r    <= b;
            borrow <= bin;
            idx    <= '0;
        end else if (state == CALC) begin
            a_r    <= a_r >> 4;
            b_r    <= b_r >> 4;
            diff_r <= (diff_r >> 4) | (W'(d) << (W - 4));
            borrow <= d_bout;
            idx    <= idx + IW'(1);
        end
    end
`ifdef BCD_SUB_INVALID_CHECK_EN
    logic err_r;
    always_ff @(posedge clk) begin
        if (rst) err_r <= 1'b0;
        else if (accept) err_r <= has_bad_digit(32'(a), DIGITS) | has_bad_digit(32'(b), DIGITS);
    end
    assign err = err_r;
`else
    assign err = 1'b0;
`endif
    assign diff = err ? '0 : diff_r;
    assign bout = ~err & borrow;
endmodule

// File: tb/tb_bcd_sub_seq.sv
// tb_bcd_sub_seq: directed and random checks of bcd_sub_seq against a decimal-arithmetic model
module tb_bcd_sub_seq;
    localparam int D = 2;
    localparam int W = 4 * D;
    localparam int M = 10 ** D;
`ifdef BCD_SUB_INVALID_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, bin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic ready, valid, bout, err;
    logic [W-1:0] diff;
    int checks = 0, errors = 0;
    bcd_sub_seq #(.DIGITS(D)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .ready(ready), .valid(valid), .diff(diff), .bout(bout), .err(err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic int val(input logic [W-1:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction
    function automatic logic bad(input logic [W-1:0] v);
        for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction
    function automatic logic [W-1:0] ediff(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        int e = val(x) - val(y) - int'(bi);
        logic [W-1:0] r = '0;
        if (CHK && (bad(x) || bad(y))) return '0;
        if (e < 0) e += M;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(e % 10);
            e = e / 10;
        end
        return r;
    endfunction
    function automatic logic ebout(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        if (CHK && (bad(x) || bad(y))) return 1'b0;
        return val(x) < val(y) + int'(bi);
    endfunction
    function automatic logic [W-1:0] rand_bcd(input int bad_pct);
        logic [W-1:0] r;
        for (int i = 0; i < D; i++)
            r[4*i +: 4] = ($urandom_range(0, 99) < bad_pct) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        return r;
    endfunction
    // Model: cnt is cycles since acceptance (0 = idle); expected outputs latch on entering the result cycle.
    int cnt = 0;
    bit armed = 1'b0;
    logic [W-1:0] pd = '0, ed = '0;
    logic pb = 1'b0, pe = 1'b0, px = 1'b0, eb = 1'b0, ee = 1'b0, ex = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            cnt <= 0; ed <= '0; eb <= 1'b0; ee <= 1'b0; ex <= 1'b0; armed <= 1'b1;
        end else if (cnt == 0) begin
            if (start) begin
                cnt <= 1;
                pd <= ediff(a, b, bin);
                pb <= ebout(a, b, bin);
                pe <= CHK && (bad(a) || bad(b));
                px <= !CHK && (bad(a) || bad(b));
            end
        end else if (cnt == D + 1) begin
            cnt <= 0;
        end else begin
            cnt <= cnt + 1;
            if (cnt == D) begin
                ed <= pd; eb <= pb; ee <= pe; ex <= px;
            end
        end
    end
    always @(negedge clk) begin
        if (armed) begin
            chk("mon_ready", 32'(ready), 32'(cnt == 0));
            chk("mon_valid", 32'(valid), 32'(cnt == D + 1));
            if (cnt == 0 || cnt == D + 1) begin
                chk("mon_err", 32'(err), 32'(ee));
                if (!ex) begin
                    chk("mon_diff", 32'(diff), 32'(ed));
                    chk("mon_bout", 32'(bout), 32'(eb));
                end
            end
        end
    end
    task automatic wait_valid(output int n, input int lim);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (valid !== 1'b1 && n < lim);
    endtask
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                      input logic [W-1:0] xd, input logic xb, input string nm);
        int n;
        @(posedge clk); #2;
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; a = rand_bcd(0); b = rand_bcd(0); bin = ~tbin;
        wait_valid(n, 10);
        chk({nm, "_lat"}, n, D + 1);
        chk({nm, "_diff"}, 32'(diff), 32'(xd));
        chk({nm, "_bout"}, 32'(bout), 32'(xb));
    endtask
    initial begin
        int n, nv;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_diff", 32'(diff), 32'd0);
        op(8'h45, 8'h23, 1'b0, 8'h22, 1'b0, "r028");
        op(8'h23, 8'h45, 1'b0, 8'h78, 1'b1, "r029a");
        op(8'h00, 8'h00, 1'b1, 8'h99, 1'b1, "r029b");
        op(8'h99, 8'h99, 1'b0, 8'h00, 1'b0, "r030a");
        op(8'h50, 8'h09, 1'b1, 8'h40, 1'b0, "r030b");
        // start during CALC with other operands must be ignored
        @(posedge clk); #2;
        a = 8'h45; b = 8'h23; bin = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        a = 8'h99; b = 8'h11;
        @(posedge clk); #2;
        start = 1'b0;
        wait_valid(n, 10);
        chk("ign_diff", 32'(diff), 32'h22);
        chk("ign_bout", 32'(bout), 32'd0);
        // back-to-back: start held high, second operands accepted on return to idle
        @(posedge clk); #2;
        a = 8'h80; b = 8'h15; bin = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        a = 8'h31; b = 8'h42;
        wait_valid(n, 10);
        chk("b2b1_diff", 32'(diff), 32'h65);
        chk("b2b1_bout", 32'(bout), 32'd0);
        wait_valid(n, 12);
        chk("b2b_gap", n, D + 2);
        chk("b2b2_diff", 32'(diff), 32'h89);
        chk("b2b2_bout", 32'(bout), 32'd1);
        @(posedge clk); #2;
        start = 1'b0;
        // reset in the second CALC cycle
        @(posedge clk); #2;
        a = 8'h77; b = 8'h12; bin = 1'b1; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_ready", 32'(ready), 32'd1);
        chk("rstmid_valid", 32'(valid), 32'd0);
        chk("rstmid_diff", 32'(diff), 32'd0);
        chk("rstmid_bout", 32'(bout), 32'd0);
        nv = 0;
        repeat (D + 3) begin
            @(negedge clk);
            if (valid === 1'b1) nv++;
        end
        chk("rstmid_novalid", nv, 0);
        // invalid digit
        @(posedge clk); #2;
        a = 8'h4A; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_valid(n, 10);
        chk("inv_lat", n, D + 1);
`ifdef BCD_SUB_INVALID_CHECK_EN
        chk("inv_err", 32'(err), 32'd1);
        chk("inv_diff", 32'(diff), 32'd0);
        chk("inv_bout", 32'(bout), 32'd0);
`else
        chk("inv_err", 32'(err), 32'd0);
`endif
        // random traffic, occasional resets and invalid digits
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk); #2;
            rst = $urandom_range(0, 99) < 2;
            start = $urandom_range(0, 1) == 1;
            a = rand_bcd(5);
            b = rand_bcd(5);
            bin = $urandom_range(0, 1) == 1;
        end
        @(posedge clk); #2;
        rst = 1'b0; start = 1'b0;
        repeat (D + 4) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_sub_seq.md
BCD_SUB_SEQ -- requirements
Module: bcd_sub_seq

Interface
REQ-001 SHALL have parameter DIGITS, default 2, meaning the number of BCD digits per operand (range 1..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only while ready=1.
REQ-005 SHALL have port a, input, 4*DIGITS bits: minuend, packed BCD, digit 0 in bits [3:0].
REQ-006 SHALL have port b, input, 4*DIGITS bits: subtrahend, packed BCD.
REQ-007 SHALL have port bin, input, 1 bit: borrow-in, applied to digit 0.
REQ-008 SHALL have port ready, output, 1 bit: block idle and able to accept start.
REQ-009 SHALL have port valid, output, 1 bit: one-cycle pulse; diff, bout and err are final.
REQ-010 SHALL have port diff, output, 4*DIGITS bits: packed BCD result.
REQ-011 SHALL have port bout, output, 1 bit: borrow-out.
REQ-012 SHALL have port err, output, 1 bit: invalid input digit detected (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; IDLE->CALC on start&ready; CALC->DONE after DIGITS cycles; DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL capture a, b and bin into internal registers on the accepting edge; later input changes SHALL NOT affect the result.
REQ-015 SHALL process one digit per CALC cycle, LSD first: t = a_i - b_i - borrow; if t<0 then digit = t+10, borrow = 1; else digit = t, borrow = 0.
REQ-016 SHALL compute diff = (a - b - bin) mod 10^DIGITS and bout = 1 iff a < b + bin, i.e. a ten's-complement result on underflow.
REQ-017 SHALL assert ready=1 only in IDLE; start in CALC or DONE SHALL be ignored, not queued.
REQ-018 SHALL assert valid for exactly one cycle (state DONE), DIGITS+1 cycles after the accepting edge.
REQ-019 SHALL hold diff, bout and err stable from valid until the next accepted start; they MAY change during CALC.
REQ-020 SHALL accept a start presented in the cycle in which DONE returns to IDLE (ready=1), giving back-to-back throughput of one result every DIGITS+2 cycles.

Reset
REQ-021 SHALL, on rst=1 at any edge, including mid-CALC, enter IDLE with ready=1 (from the next cycle), valid=0, diff=0, bout=0, err=0, and the internal borrow and digit index cleared.
REQ-022 SHALL give rst priority over start in the same cycle; that start SHALL be dropped.

Configuration
REQ-023 SHALL use macro BCD_SUB_INVALID_CHECK_EN.
REQ-024 With BCD_SUB_INVALID_CHECK_EN defined: at accept, err SHALL be set if any digit of a or b exceeds 9; at valid, diff=0 and bout=0 when err=1.
REQ-025 Without BCD_SUB_INVALID_CHECK_EN: port err SHALL remain, tied to 0, and digits above 9 SHALL be processed by REQ-015 arithmetic with an unspecified result.

Structure
REQ-026 SHALL place the FSM state enum, BCD_RADIX=10 and BCD_MAX=9 in shared package bcd_sub_pkg.
REQ-027 SHALL implement the per-digit step as combinational sub-module bcd_digit_sub (inputs a_d, b_d, bin; outputs d, bout), reused every CALC cycle.

Verification
REQ-028 SHALL cover: DIGITS=2, a=0x45, b=0x23, bin=0 -> valid 3 cycles after accept, diff=0x22, bout=0.
REQ-029 SHALL cover: a=0x23, b=0x45, bin=0 -> diff=0x78, bout=1; then a=0x00, b=0x00, bin=1 -> diff=0x99, bout=1.
REQ-030 SHALL cover: a=0x99, b=0x99, bin=0 -> diff=0x00, bout=0; then a=0x50, b=0x09, bin=1 -> diff=0x40, bout=0.
REQ-031 SHALL cover: start pulsed during CALC with different operands -> ignored, first result unchanged; back-to-back start at ready -> second result after DIGITS+2 cycles.
REQ-032 SHALL cover: rst asserted in the second CALC cycle -> next cycle ready=1, valid=0, diff=0, bout=0, and no valid pulse follows.
REQ-033 SHALL cover, with BCD_SUB_INVALID_CHECK_EN defined: a=0x4A, b=0x01 -> err=1, diff=0, bout=0; without the macro, err stays 0.
